// File: rtl/l15_data_ram_arbiter_pkg.sv
// Shared types and width helpers for the L1.5 data RAM arbiter.
// Build option: L15_DATA_INIT_EN enables the post-reset zero-fill sequencer.
package l15_data_arb_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } arb_state_e;

   // Index width that stays legal (>=1 bit) for a count of n items.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/l15_data_ram_arbiter_if.sv
// Requester, refill and RAM-side signals of the L1.5 data RAM arbiter.
interface l15_data_ram_arbiter_if #(
   parameter int unsigned NB_READERS = 4,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned ADDR_WIDTH = 6
);
   localparam int unsigned BE_W = DATA_WIDTH / 8;

   logic [NB_READERS-1:0]                 rd_req_i;
   logic [NB_READERS-1:0][ADDR_WIDTH-1:0] rd_addr_i;
   logic [NB_READERS-1:0]                 rd_gnt_o;
   logic [NB_READERS-1:0]                 rd_rvalid_o;
   logic [DATA_WIDTH-1:0]                 rd_rdata_o;
   logic                                  wr_req_i;
   logic [ADDR_WIDTH-1:0]                 wr_addr_i;
   logic [DATA_WIDTH-1:0]                 wr_data_i;
   logic [BE_W-1:0]                       wr_be_i;
   logic                                  wr_gnt_o;
   logic                                  ram_req_o;
   logic                                  ram_write_o;
   logic [ADDR_WIDTH-1:0]                 ram_addr_o;
   logic [DATA_WIDTH-1:0]                 ram_wdata_o;
   logic [BE_W-1:0]                       ram_be_o;
   logic [DATA_WIDTH-1:0]                 ram_rdata_i;
   logic                                  init_done_o;

   // Arbiter side.
   modport slave (
      input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i, wr_be_i, ram_rdata_i,
      output rd_gnt_o, rd_rvalid_o, rd_rdata_o, wr_gnt_o,
             ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_be_o, init_done_o
   );

   // Requesters plus RAM wrapper side.
   modport master (
      output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i, wr_be_i, ram_rdata_i,
      input  rd_gnt_o, rd_rvalid_o, rd_rdata_o, wr_gnt_o,
             ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_be_o, init_done_o
   );

endinterface

// File: rtl/l15_data_ram_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module l15_rr_picker
   import l15_data_arb_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]              req_i,
   input  logic [idx_width(N)-1:0]   ptr_i,
   output logic [N-1:0]              gnt_o,
   output logic [idx_width(N)-1:0]   idx_o,
   output logic                      valid_o
);
   localparam int unsigned PW = idx_width(N);

   always_comb begin
      logic [PW-1:0] k;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      k       = '0;
      for (int unsigned i = 0; i < N; i++) begin
         k = PW'((32'(ptr_i) + i) % N);
         if (!valid_o && req_i[k]) begin
            gnt_o[k] = 1'b1;
            idx_o    = k;
            valid_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/l15_data_ram_arbiter.sv
// Single-port L1.5 data RAM arbiter: bounded-priority refill writes, round-robin reads.
// Build option: L15_DATA_INIT_EN adds a post-reset zero-fill of the whole RAM.
module l15_data_ram_arbiter
   import l15_data_arb_pkg::*;
#(
   parameter int unsigned NB_READERS   = 4,
   parameter int unsigned DATA_WIDTH   = 128,
   parameter int unsigned ADDR_WIDTH   = 6,
   parameter int unsigned MAX_WR_BURST = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   l15_data_ram_arbiter_if.slave bus
);
   localparam int unsigned PTR_W = idx_width(NB_READERS);
   localparam int unsigned CNT_W = idx_width(MAX_WR_BURST + 1);

   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
   logic [NB_READERS-1:0] rvalid_q, rvalid_d;
   logic [NB_READERS-1:0] pick_gnt;
   logic [PTR_W-1:0]      pick_idx;
   logic                  pick_valid;
   logic                  run_c;
   logic                  wr_win_c;

`ifdef L15_DATA_INIT_EN
   arb_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
`endif

   l15_rr_picker #(.N(NB_READERS)) u_rr_picker (
      .req_i   (bus.rd_req_i),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   assign bus.rd_rvalid_o = rvalid_q;
   assign bus.rd_rdata_o  = bus.ram_rdata_i;

   // Next-state and RAM port drive; everything is forced idle while rst is high.
   always_comb begin
      rr_ptr_d        = rr_ptr_q;
      wr_cnt_d        = wr_cnt_q;
      rvalid_d        = '0;
      run_c           = 1'b0;
      wr_win_c        = 1'b0;
      bus.rd_gnt_o    = '0;
      bus.wr_gnt_o    = 1'b0;
      bus.ram_req_o   = 1'b0;
      bus.ram_write_o = 1'b0;
      bus.ram_addr_o  = '0;
      bus.ram_wdata_o = '0;
      bus.ram_be_o    = '0;
      bus.init_done_o = 1'b1;
`ifdef L15_DATA_INIT_EN
      state_d         = state_q;
      init_addr_d     = init_addr_q;
      bus.init_done_o = (state_q == RUN);
      run_c           = !rst && (state_q == RUN);
      if (!rst && (state_q == INIT)) begin
         bus.ram_req_o   = 1'b1;
         bus.ram_write_o = 1'b1;
         bus.ram_addr_o  = init_addr_q;
         bus.ram_be_o    = '1;
         init_addr_d     = init_addr_q + ADDR_WIDTH'(1);
         if (init_addr_q == '1) begin
            state_d = RUN;
         end
      end
`else
      run_c = !rst;
`endif
      if (run_c) begin
         // A pending read only blocks the refill once the burst budget is spent.
         wr_win_c = bus.wr_req_i && !(pick_valid && (wr_cnt_q == CNT_W'(MAX_WR_BURST)));
         if (wr_win_c) begin
            bus.wr_gnt_o    = 1'b1;
            bus.ram_req_o   = 1'b1;
            bus.ram_write_o = 1'b1;
            bus.ram_addr_o  = bus.wr_addr_i;
            bus.ram_wdata_o = bus.wr_data_i;
            bus.ram_be_o    = bus.wr_be_i;
         end else if (pick_valid) begin
            bus.rd_gnt_o   = pick_gnt;
            bus.ram_req_o  = 1'b1;
            bus.ram_addr_o = bus.rd_addr_i[pick_idx];
            rvalid_d       = pick_gnt;
            rr_ptr_d       = (32'(pick_idx) == NB_READERS - 1) ? '0 : pick_idx + PTR_W'(1);
         end
         if (!pick_valid || !wr_win_c) begin
            wr_cnt_d = '0;
         end else if (wr_cnt_q != CNT_W'(MAX_WR_BURST)) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= '0;
         wr_cnt_q <= '0;
         rvalid_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         wr_cnt_q <= wr_cnt_d;
         rvalid_q <= rvalid_d;
      end
   end

`ifdef L15_DATA_INIT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= INIT;
         init_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
      end
   end
`endif

endmodule

// File: doc/l15_data_ram_arbiter.md
# l15_data_ram_arbiter

Sequencer and arbiter for one single-port L1.5 instruction-cache data RAM. Shares the RAM between NB_READERS read requesters (per-bank fetch paths) and one refill write port, with write priority bounded by a starvation counter and round-robin among readers. Optionally zero-initialises the whole RAM after reset. Sits between the L1.5 cache controller/refill unit and the data RAM wrapper.

## Interface
- NB_READERS, 4: number of read requesters (≥2).
- DATA_WIDTH, 128: RAM word width (multiple of 8).
- ADDR_WIDTH, 6: RAM address width; depth = 2**ADDR_WIDTH.
- MAX_WR_BURST, 4: consecutive write grants allowed while a read is pending (≥1).

- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- rd_req_i  in  NB_READERS  read request per reader.
- rd_addr_i  in  NB_READERS×ADDR_WIDTH  read address per reader.
- rd_gnt_o  out  NB_READERS  one-hot read grant (combinational).
- rd_rvalid_o  out  NB_READERS  one-hot read-data valid, one cycle after grant.
- rd_rdata_o  out  DATA_WIDTH  read data, shared by all readers, equals ram_rdata_i.
- wr_req_i  in  1  refill write request.
- wr_addr_i  in  ADDR_WIDTH  write address.
- wr_data_i  in  DATA_WIDTH  write data.
- wr_be_i  in  DATA_WIDTH/8  byte enables.
- wr_gnt_o  out  1  write grant (combinational).
- ram_req_o, ram_write_o  out  1 each  RAM strobe and write select.
- ram_addr_o  out  ADDR_WIDTH; ram_wdata_o  out  DATA_WIDTH; ram_be_o  out  DATA_WIDTH/8.
- ram_rdata_i  in  DATA_WIDTH  RAM output, valid one cycle after read strobe.
- init_done_o  out  1  high when arbiter accepts requests.

## Operation
- States: INIT, RUN. Reset state INIT if L15_DATA_INIT_EN defined, else RUN.
- INIT: counter init_addr from 0; each cycle ram_req_o=1, ram_write_o=1, ram_addr_o=init_addr, wdata=0, be all-ones; after address 2**ADDR_WIDTH−1, go RUN. No grants in INIT.
- RUN, per cycle, exactly one RAM access at most:
  - Write wins if wr_req_i and NOT (any rd_req_i and wr_cnt==MAX_WR_BURST).
  - Otherwise, if any rd_req_i, grant reader found first searching from rr_ptr upward, wrapping at NB_READERS.
- rr_ptr: on a read grant to index k, rr_ptr ← (k+1) mod NB_READERS; unchanged otherwise. Reset 0.
- wr_cnt (width clog2(MAX_WR_BURST+1)): +1 on write grant while any read pending (saturating); ← 0 on read grant or when no read pending. Reset 0.
- Write grant drives ram_write_o=1 with wr_* fields; read grant drives ram_write_o=0, ram_addr_o=granted address, be=0, wdata=0.
- rvalid register: one-hot of granted reader, captured each cycle; rd_rvalid_o is that register.
- Idle: ram_req_o=0, all other ram_* outputs 0.

## Timing
- Reset values: rd_gnt_o=0, wr_gnt_o=0, rd_rvalid_o=0, ram_req_o=0, ram_write_o=0, ram_* 0; init_done_o=0 (with macro) / 1 (without).
- Grant same cycle as request; requester holds req/addr until granted.
- Read latency: rd_rvalid_o[k] asserted exactly one cycle after rd_gnt_o[k]; back-to-back grants give back-to-back rvalid.
- init_done_o rises the cycle after the last init write; total init = 2**ADDR_WIDTH cycles.
- rst mid-INIT restarts at address 0; rst mid-RUN drops pending rvalid.

## Configuration
- L15_DATA_INIT_EN defined: INIT state, init counter, and zero-fill present.
- Undefined: no INIT logic; block enters RUN directly from reset; init_done_o tied 1.

## Structure
- l15_data_arb_pkg: state enum (INIT, RUN), width helper constants.
- Sub-module l15_rr_picker: combinational one-hot pick of requests from a pointer, with wrap-around.

## Test plan
- With macro, ADDR_WIDTH=6: release reset -> 64 consecutive writes addr 0..63 data 0, init_done_o high at cycle 65.
- All 4 readers request continuously -> grants 0,1,2,3,0… one per cycle, rvalid one cycle later each.
- wr_req_i and rd_req_i[2] held high, MAX_WR_BURST=4 -> 4 write grants, 1 read grant to reader 2, repeat.
- Only write requests, 10 cycles -> 10 write grants, wr_cnt stays 0.
- Reader 3 granted, rr_ptr=0 next; readers 0 and 3 request -> reader 0 granted.
- rst asserted at init address 20 -> after release init restarts from address 0.
